// File: rtl/wave_key_ctrl_if.sv
// Front-panel key inputs and the control words handed to the DAC driver.
// The controller uses the slave view; the panel/driver side uses the master view.
interface wave_key_ctrl_if;
   logic [1:0] Key;
   logic [1:0] Wave_Mode;
   logic [8:0] Phase;
   logic       DAC_En;
   logic       Mode_Changed;

   modport master (output Key, input Wave_Mode, Phase, DAC_En, Mode_Changed);
   modport slave  (input Key, output Wave_Mode, Phase, DAC_En, Mode_Changed);
endinterface

// File: rtl/wave_key_ctrl.sv
// Debounces the two front-panel keys and turns them into registered wave mode,
// phase offset and DAC enable words, with hold-to-repeat on the phase key.
module wave_key_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 32'd2000000,
   parameter int unsigned HOLD_CYCLES     = 32'd50000000,
   parameter int unsigned REPEAT_CYCLES   = 32'd20000000,
   parameter int unsigned PHASE_STEP      = 32'd45,
   parameter int unsigned PHASE_INIT      = 32'd180
) (
   input  logic           clk_100MHz,
   input  logic           rst,
   wave_key_ctrl_if.slave kif
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 32'd1);
   localparam int unsigned RC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned RC_W   = $clog2(RC_MAX + 32'd1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [RC_W-1:0] HOLD_LAST = RC_W'(HOLD_CYCLES - 32'd1);
   localparam logic [RC_W-1:0] REP_LAST  = RC_W'(REPEAT_CYCLES - 32'd1);
   localparam logic [9:0]      STEP10    = 10'(PHASE_STEP);
   localparam logic [8:0]      INIT9     = 9'(PHASE_INIT);

   typedef enum logic [1:0] {
      K1_IDLE      = 2'd0,
      K1_WAIT_HOLD = 2'd1,
      K1_REPEAT    = 2'd2,
      K1_LOCK      = 2'd3
   } k1_state_t;

   // Modulo-360 add; STEP10 < 360 so one subtraction always suffices.
   function automatic logic [8:0] f_phase_add(input logic [8:0] phase);
      logic [9:0] sum;
      sum = {1'b0, phase} + STEP10;
      if (sum >= 10'd360) begin
         f_phase_add = 9'(sum - 10'd360);
      end else begin
         f_phase_add = sum[8:0];
      end
   endfunction

   logic [1:0]      r_sync1;
   logic [1:0]      r_sync2;
   logic [1:0]      r_stable;
   logic [1:0]      r_stable_d;
   logic [DB_W-1:0] r_db_cnt [2];
   k1_state_t       r_state;
   logic [RC_W-1:0] r_rc;
   logic [1:0]      r_wave_mode;
   logic [8:0]      r_phase;
   logic            r_dac_en;
   logic            r_mode_changed;

   logic [1:0]      w_press;
   logic            w_dac_tgl;
   logic            w_mode_inc;
   logic            w_step;

   // Synchronize the raw keys and accept a level only after it stays stable.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         r_sync1    <= 2'b00;
         r_sync2    <= 2'b00;
         r_stable   <= 2'b00;
         r_stable_d <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_db_cnt[i] <= {DB_W{1'b0}};
         end
      end else begin
         r_sync1    <= kif.Key;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_db_cnt[i] <= {DB_W{1'b0}};
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_stable[i] <= r_sync2[i];
               r_db_cnt[i] <= {DB_W{1'b0}};
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1'b1);
            end
         end
      end
   end

   // A same-cycle double press satisfies both combo terms, so the OR toggles DAC_En once.
   always_comb begin
      w_press    = r_stable & ~r_stable_d;
      w_dac_tgl  = (w_press[0] & r_stable[1]) |
                   (w_press[1] & r_stable[0] & (r_state == K1_IDLE));
      w_mode_inc = w_press[0] & ~r_stable[1];
      case (r_state)
         K1_IDLE:      w_step = w_press[1] & ~r_stable[0];
         K1_WAIT_HOLD: w_step = r_stable[1] & (r_rc == HOLD_LAST);
         K1_REPEAT:    w_step = r_stable[1] & (r_rc == REP_LAST);
         default:      w_step = 1'b0;
      endcase
   end

   // Key[1] hold/repeat state machine and the registered control words.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         r_state        <= K1_IDLE;
         r_rc           <= {RC_W{1'b0}};
         r_wave_mode    <= 2'd0;
         r_phase        <= INIT9;
         r_dac_en       <= 1'b1;
         r_mode_changed <= 1'b0;
      end else begin
         case (r_state)
            K1_IDLE: begin
               if (w_press[1]) begin
                  r_rc    <= {RC_W{1'b0}};
                  r_state <= r_stable[0] ? K1_LOCK : K1_WAIT_HOLD;
               end
            end
            K1_WAIT_HOLD: begin
               if (!r_stable[1]) begin
                  r_state <= K1_IDLE;
               end else if (r_rc == HOLD_LAST) begin
                  r_rc    <= {RC_W{1'b0}};
                  r_state <= K1_REPEAT;
               end else begin
                  r_rc <= r_rc + RC_W'(1'b1);
               end
            end
            K1_REPEAT: begin
               if (!r_stable[1]) begin
                  r_state <= K1_IDLE;
               end else if (r_rc == REP_LAST) begin
                  r_rc <= {RC_W{1'b0}};
               end else begin
                  r_rc <= r_rc + RC_W'(1'b1);
               end
            end
            K1_LOCK: begin
               if (!r_stable[1]) begin
                  r_state <= K1_IDLE;
               end
            end
            default: r_state <= K1_IDLE;
         endcase

         if (w_mode_inc) begin
            r_wave_mode <= r_wave_mode + 2'd1;
         end
         if (w_dac_tgl) begin
            r_dac_en <= ~r_dac_en;
         end
         if (w_step) begin
            r_phase <= f_phase_add(r_phase);
         end
         r_mode_changed <= w_mode_inc | w_dac_tgl | w_step;
      end
   end

   assign kif.Wave_Mode    = r_wave_mode;
   assign kif.Phase        = r_phase;
   assign kif.DAC_En       = r_dac_en;
   assign kif.Mode_Changed = r_mode_changed;

endmodule
